// File: rtl/m_pkg.sv
// Shared decode constants, state encoding and operand-class helpers for the
// PCPI M-extension unit.
package m_pkg;

  localparam logic [6:0] OPCODE = 7'b0110011;
  localparam logic [6:0] FUNC7  = 7'b0000001;

  typedef enum logic [2:0] {
    F_MUL    = 3'd0,
    F_MULH   = 3'd1,
    F_MULHSU = 3'd2,
    F_MULHU  = 3'd3,
    F_DIV    = 3'd4,
    F_DIVU   = 3'd5,
    F_REM    = 3'd6,
    F_REMU   = 3'd7
  } func3_t;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  function automatic logic is_mult(input func3_t f);
    return !f[2];
  endfunction

  function automatic logic is_div(input func3_t f);
    return f[2] && !f[1];
  endfunction

  function automatic logic is_rem(input func3_t f);
    return f[2] && f[1];
  endfunction

  function automatic logic rs1_is_signed(input func3_t f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic rs2_is_signed(input func3_t f);
    return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

  // An operand is negative only if it is treated as signed and its MSB is set.
  function automatic logic is_negative(input logic msb, input logic sgn);
    return msb && sgn;
  endfunction

endpackage

// File: rtl/m_div_iter.sv
// One divider cycle: DIV_STEP restoring compare/subtract steps on the partial
// remainder, consuming DIV_STEP dividend bits MSB first.
module m_div_iter #(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 2
) (
  input  logic [XLEN-1:0]     r,
  input  logic [XLEN-1:0]     d,
  input  logic [DIV_STEP-1:0] bits,
  output logic [XLEN-1:0]     r_next,
  output logic [DIV_STEP-1:0] q_bits
);

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] acc;

  // Remainder stays below the divisor, so the shifted trial fits in XLEN+1 bits.
  always_comb begin
    acc    = r;
    trial  = '0;
    q_bits = '0;
    for (int i = DIV_STEP - 1; i >= 0; i--) begin
      trial = {acc, bits[i]};
      if (trial >= {1'b0, d}) begin
        trial     = trial - {1'b0, d};
        q_bits[i] = 1'b1;
      end
      acc = trial[XLEN-1:0];
    end
    r_next = acc;
  end

endmodule

// File: rtl/pcpi_m_unit_param.sv
// PCPI M-extension coprocessor: pipelined multiplier, radix-2^DIV_STEP
// restoring divider, divide special cases and DIV/REM result fusion.
module pcpi_m_unit_param
  import m_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 2,
  parameter int MUL_LAT  = 2,
  parameter int FUSE_EN  = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready,
  output logic            pcpi_busy
);

  localparam int N  = XLEN / DIV_STEP;
  localparam int CW = $clog2(N);

  state_t          state;
  logic [CW-1:0]   cnt;
  func3_t          func_q;
  logic            neg_q, neg_r;

  // Divider datapath: z_q holds the dividend shifting out and quotient shifting in.
  logic [XLEN-1:0] z_q, rem_q, dvs_q, r_next;
  logic [DIV_STEP-1:0] q_bits;

  logic [2*XLEN-1:0] prod_p [MUL_LAT];

  logic            tag_vld, tag_sgn;
  logic [XLEN-1:0] tag_rs1, tag_rs2, tag_q, tag_r;

  logic            unused_insn;
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // Decode and accept-cycle operand conditioning.
  func3_t          f_in;
  logic            dec, accept, div_in, s1_in, s2_in, n1_in, n2_in;
  logic [XLEN-1:0] abs1_in, abs2_in;

  assign dec     = (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[31:25] == FUNC7);
  assign f_in    = func3_t'(pcpi_insn[14:12]);
  assign accept  = (state == IDLE) && pcpi_valid && dec;
  assign div_in  = !is_mult(f_in);
  assign s1_in   = rs1_is_signed(f_in);
  assign s2_in   = rs2_is_signed(f_in);
  assign n1_in   = is_negative(pcpi_rs1[XLEN-1], s1_in);
  assign n2_in   = is_negative(pcpi_rs2[XLEN-1], s2_in);
  assign abs1_in = n1_in ? -pcpi_rs1 : pcpi_rs1;
  assign abs2_in = n2_in ? -pcpi_rs2 : pcpi_rs2;

  // Divide shortcuts resolved at accept; quotient and remainder both kept for fusion.
  logic            zero_div, ovf, early, special, hit, fast;
  logic [XLEN-1:0] sp_q, sp_r, fast_res;

  assign zero_div = (pcpi_rs2 == '0);
  assign ovf      = s1_in && (pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&pcpi_rs2);
  assign early    = abs1_in < abs2_in;
  assign special  = zero_div || ovf || early;
  assign hit      = (FUSE_EN != 0) && tag_vld && (tag_rs1 == pcpi_rs1) &&
                    (tag_rs2 == pcpi_rs2) && (tag_sgn == s1_in);
  assign fast     = div_in && (special || hit);

  // Special-case results in priority order: divide by zero, overflow, early-out.
  always_comb begin
    sp_q = '0;
    sp_r = pcpi_rs1;
    if (zero_div) begin
      sp_q = '1;
    end else if (ovf) begin
      sp_q = pcpi_rs1;
      sp_r = '0;
    end
    if (special) fast_res = is_rem(f_in) ? sp_r : sp_q;
    else         fast_res = is_rem(f_in) ? tag_r : tag_q;
  end

  m_div_iter #(.XLEN(XLEN), .DIV_STEP(DIV_STEP)) u_step (
    .r      (rem_q),
    .d      (dvs_q),
    .bits   (z_q[XLEN-1 -: DIV_STEP]),
    .r_next (r_next),
    .q_bits (q_bits)
  );

  logic [XLEN-1:0]   q_fix, r_fix, mul_res;
  logic [2*XLEN-1:0] prod_s;

  assign q_fix   = neg_q ? -z_q : z_q;
  assign r_fix   = neg_r ? -rem_q : rem_q;
  assign prod_s  = neg_q ? -prod_p[MUL_LAT-1] : prod_p[MUL_LAT-1];
  assign mul_res = (func_q == F_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

  // Control FSM with registered result; abort on pcpi_valid drop drops the tag too.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      func_q  <= F_MUL;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      tag_vld <= 1'b0;
      pcpi_rd <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          func_q <= f_in;
          neg_q  <= n1_in ^ n2_in;
          neg_r  <= n1_in;
          cnt    <= '0;
          if (!div_in) begin
            state   <= MUL;
            tag_vld <= 1'b0;
          end else if (fast) begin
            state   <= DONE;
            pcpi_rd <= fast_res;
            if (special) tag_vld <= (FUSE_EN != 0);
          end else begin
            state <= DIV;
          end
        end
        MUL: begin
          if (!pcpi_valid) begin
            state   <= IDLE;
            tag_vld <= 1'b0;
          end else if (cnt == CW'(MUL_LAT - 1)) begin
            state   <= DONE;
            pcpi_rd <= mul_res;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (!pcpi_valid) begin
            state   <= IDLE;
            tag_vld <= 1'b0;
          end else if (cnt == CW'(N - 1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!pcpi_valid) begin
            state   <= IDLE;
            tag_vld <= 1'b0;
          end else begin
            state   <= DONE;
            pcpi_rd <= is_rem(func_q) ? r_fix : q_fix;
            tag_vld <= (FUSE_EN != 0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers: multiplier pipeline, divider iteration, fusion tag.
  always_ff @(posedge clk) begin
    prod_p[0] <= {{XLEN{1'b0}}, abs1_in} * {{XLEN{1'b0}}, abs2_in};
    for (int i = 1; i < MUL_LAT; i++) prod_p[i] <= prod_p[i-1];

    if (accept) begin
      z_q   <= abs1_in;
      rem_q <= '0;
      dvs_q <= abs2_in;
    end else if (state == DIV) begin
      z_q   <= {z_q[XLEN-DIV_STEP-1:0], q_bits};
      rem_q <= r_next;
    end

    if (accept && div_in && special) begin
      tag_rs1 <= pcpi_rs1;
      tag_rs2 <= pcpi_rs2;
      tag_sgn <= s1_in;
      tag_q   <= sp_q;
      tag_r   <= sp_r;
    end else if (state == FIX && pcpi_valid) begin
      tag_rs1 <= pcpi_rs1;
      tag_rs2 <= pcpi_rs2;
      tag_sgn <= rs1_is_signed(func_q);
      tag_q   <= q_fix;
      tag_r   <= r_fix;
    end
  end

  assign pcpi_ready = (state == DONE);
  assign pcpi_wr    = pcpi_ready;
  assign pcpi_busy  = (state != IDLE);
  assign pcpi_wait  = resetn && pcpi_valid && ((state != IDLE) || dec);

endmodule

// File: tb/tb_pcpi_m_unit_param.sv
// Scoreboard bench for pcpi_m_unit_param (XLEN=32, DIV_STEP=2, MUL_LAT=2, FUSE_EN=1).
module tb_pcpi_m_unit_param;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, pcpi_busy;
  logic [31:0] pcpi_rd;

  pcpi_m_unit_param #(.XLEN(32), .DIV_STEP(2), .MUL_LAT(2), .FUSE_EN(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .pcpi_busy  (pcpi_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    int          at;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ready_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Monitor: every completion strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (pcpi_ready) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.nm, "_rd"}, 64'(pcpi_rd), 64'(e.rd));
        check({e.nm, "_cycle"}, 64'(cyc), 64'(e.at));
        check({e.nm, "_wr"}, 64'(pcpi_wr), 64'd1);
      end
    end
  end

  // Issue one instruction, hold pcpi_valid until completion, then release.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] rd, input int lat);
    bit got = 0;
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk(f3, 7'b0000001);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    exp_q.push_back('{rd: rd, at: cyc + lat, nm: nm});
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = pcpi_ready;
    end
    if (!got) begin
      check({nm, "_timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
  endtask

  initial begin
    int st, rc0;
    logic [3:0] acc;
    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    repeat (2) @(negedge clk);
    check("reset_flags", 64'({pcpi_wait, pcpi_ready, pcpi_wr, pcpi_busy}), 64'd0);
    check("reset_rd", 64'(pcpi_rd), 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // Multiply: 3-cycle latency
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3);
    run_op("mul_m1",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3);
    run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 3);

    // Divide, fusion hit, signedness mismatch
    run_op("div_m7",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 18);
    run_op("rem_fuse", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);
    run_op("remu_nf",  3'd7, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 18);

    // Special cases
    run_op("divu_z",   3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_z",    3'd6, 32'd5, 32'd0, 32'h0000_0005, 1);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("divu_eo",  3'd5, 32'd3, 32'd10, 32'd0, 1);
    run_op("remu_eo",  3'd7, 32'd3, 32'd10, 32'd3, 1);
    run_op("divu_max", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 18);

    // A MUL between DIV and REM invalidates the fusion tag
    run_op("div_100",  3'd4, 32'd100, 32'd7, 32'd14, 18);
    run_op("mul_3x4",  3'd0, 32'd3, 32'd4, 32'd12, 3);
    run_op("rem_100",  3'd6, 32'd100, 32'd7, 32'd2, 18);
    run_op("divu_100", 3'd5, 32'd100, 32'd7, 32'd14, 18);
    run_op("remu_fuse",3'd7, 32'd100, 32'd7, 32'd2, 1);

    // Abort: drop pcpi_valid at cycle 6 of a DIV
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = mk(3'd4, 7'b0000001);
    pcpi_rs1 = 32'hFFFF_FFF9; pcpi_rs2 = 32'd2;
    st = cyc;
    rc0 = ready_cnt;
    repeat (6) @(posedge clk);
    #1 pcpi_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_c6", 64'(pcpi_busy), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_cycle", 64'(cyc - st), 64'd8);
    check("abort_busy_c8", 64'(pcpi_busy), 64'd0);
    repeat (15) @(negedge clk);
    check("abort_no_ready", 64'(ready_cnt - rc0), 64'd0);

    // Abort also drops the fusion tag; the unit then works normally
    run_op("rem_after_abort", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 18);
    run_op("mulhu",           3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 3);

    // Reset in the middle of a MUL
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = mk(3'd0, 7'b0000001);
    pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd4;
    @(posedge clk); #1;
    check("mid_mul_busy", 64'(pcpi_busy), 64'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_flags", 64'({pcpi_wait, pcpi_ready, pcpi_wr, pcpi_busy}), 64'd0);
    check("rst_mid_rd", 64'(pcpi_rd), 64'd0);
    pcpi_valid = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    rc0 = ready_cnt;
    repeat (6) @(negedge clk);
    check("rst_no_ready", 64'(ready_cnt - rc0), 64'd0);

    // Non-M instruction (funct7 = 0) is ignored
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = mk(3'd0, 7'b0000000);
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc = acc | {pcpi_wait, pcpi_busy, pcpi_ready, pcpi_wr};
    end
    check("non_m_ignored", 64'(acc), 64'd0);
    @(posedge clk); #1 pcpi_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
